// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: state encoding, default width
// and the detector pattern that the serializer feeds.
package byte_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [7:0] DETECT_PATTERN = 8'b10010110;

endpackage

// File: rtl/byte_serializer_hold_reg.sv
// One-entry holding buffer with a valid/ready handshake in front of the
// serializer's shift register.
module byte_serializer_hold_reg
  import byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  take,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_full
);

  logic transfer;

  assign load_ready = ~hold_full & ~Reset;
  assign transfer   = load_valid & load_ready;

  // take only fires while full, so it never coincides with a transfer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_full <= 1'b0;
    end else if (transfer) begin
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (transfer) begin
      hold_data <= load_data;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter feeding the sequence detector; a holding
// register lets consecutive words stream out without idle bits in between.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  byte_done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_full;
  logic                    take;
  logic                    out_bit;

  byte_serializer_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_reg (
    .Clock      (Clock),
    .Reset      (Reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .take       (take),
    .hold_data  (hold_data),
    .hold_full  (hold_full)
  );

  // A pending word is pulled in either from idle or on a frame's last bit,
  // which is what makes back-to-back frames gapless.
  assign take    = hold_full & ((state == IDLE) | (bit_cnt == '0));
  assign out_bit = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hold_full) state_next = SHIFT;
      SHIFT:   if ((bit_cnt == '0) && !hold_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ser_valid = (state == SHIFT);
    byte_done = (state == SHIFT) && (bit_cnt == '0);
    ser_out   = (state == SHIFT) ? out_bit : IDLE_LEVEL;
    busy      = (state == SHIFT) || hold_full;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (take) begin
      shift_reg <= hold_data;
      bit_cnt   <= LAST_CNT;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      end
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

endmodule
